psum_deskew: RTL and testbench
==============================

PSUM_DESKEW -- requirements
Module: psum_deskew

Interface
REQ-001 Parameter COL, default 32: systolic column count.
REQ-002 Parameter DW, default 16: signed partial-sum width per column.
REQ-003 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 nrst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse; samples configuration and begins a drain.
REQ-007 num_filter  in  5  active column count K; columns 0..K-1 are used.
REQ-008 num_pixels  in  10  aligned vectors to collect per drain.
REQ-009 relu_en  in  1  clamp negative results to zero.
REQ-010 col_valid  in  COL  per-column output enable from the array controller.
REQ-011 col_psum  in  COL*DW  per-column partial sums; column c at bits [c*DW +: DW].
REQ-012 out_valid  out  1  FIFO head valid.
REQ-013 out_ready  in  1  consumer accepts the head when out_valid is high.
REQ-014 out_data  out  COL*DW  aligned vector, same column packing as col_psum.
REQ-015 out_pix  out  10  pixel index of the head vector.
REQ-016 busy  out  1  high in DRAIN or FLUSH.
REQ-017 done  out  1  one-cycle pulse at drain completion.
REQ-018 overflow  out  1  sticky; a vector was dropped.

Function
REQ-019 States: IDLE, DRAIN, FLUSH, DONE.
REQ-020 start in any state latches K, num_pixels and relu_en, clears FIFO, pixel counter, delay lines and overflow, and enters DRAIN.
REQ-021 start with K=0 or num_pixels=0 goes to DONE instead of DRAIN; no vectors are produced.
REQ-022 Column c (c<K) data and valid pass through a delay of K-1-c cycles; column K-1 has zero delay.
REQ-023 Columns c>=K are ignored; their out_data lanes are zero.
REQ-024 An aligned vector exists in a cycle when the delayed valid of column K-1 is high in DRAIN.
REQ-025 Each aligned vector, ReLU-applied when relu_en is set (signed value <0 becomes 0), is pushed with the current pixel counter value; the counter then increments.
REQ-026 When the counter reaches num_pixels, DRAIN goes to FLUSH; later aligned vectors are discarded.
REQ-027 FLUSH goes to DONE in the cycle the FIFO becomes empty; DONE asserts done for one cycle and returns to IDLE.
REQ-028 Push-to-out_valid latency is 1 cycle when the FIFO is empty.
REQ-029 Head pops when out_valid and out_ready are both high; data holds stable while out_valid is high and out_ready is low.
REQ-030 A push with the FIFO full and no pop in that cycle is dropped and sets overflow; the pixel counter still increments.
REQ-031 Simultaneous push and pop while full is accepted without loss.
REQ-032 col_valid in IDLE or DONE is ignored.

Reset
REQ-033 On nrst low: state IDLE; FIFO, delay lines and pixel counter cleared; out_valid, busy, done and overflow are 0; out_data and out_pix are 0.
REQ-034 Reset mid-drain abandons the drain with no done pulse.

Verification
REQ-035 K=3, num_pixels=2, columns staggered one cycle (col c valid from cycle c), out_ready=1 -> two vectors, out_pix 0 then 1, lanes 0..2 matched per pixel, lanes 3..31 zero, then a single done pulse.
REQ-036 relu_en=1 with a column-1 value of -5 (0xFFFB) and a column-0 value of 7 -> lane1=0 and lane0=7.
REQ-037 out_ready=0 with num_pixels=6 and FIFO_DEPTH=4 -> 4 vectors held, overflow=1, out_pix 0..3 drained after out_ready rises.
REQ-038 start with K=0 -> done asserted 2 cycles later, out_valid is never asserted.
REQ-039 nrst pulled low during DRAIN with 2 vectors queued -> out_valid=0, busy=0 and overflow=0 next cycle; done is never asserted.
REQ-040 start reissued mid-DRAIN with K=4 -> FIFO emptied, out_pix restarts at 0, and the new alignment uses delay 3 for column 0.

Source files
------------

// File: rtl/psum_deskew_if.sv
// psum_deskew_if
// Carries the systolic array's column outputs into the deskew block, and the aligned
// vector stream out of the block toward the consumer.
//   col_valid  per-column output enable from the array controller
//   col_psum   per-column partial sums; column c at bits [c*DW +: DW]
//   out_valid  aligned-vector FIFO head valid
//   out_ready  consumer accepts the head when out_valid is high
//   out_data   aligned vector, same packing as col_psum
//   out_pix    pixel index of the head vector
// Modports: slave = deskew block, master = array side / consumer.
interface psum_deskew_if #(
    parameter int COL = 32,
    parameter int DW  = 16
);
    logic [COL-1:0]    col_valid;
    logic [COL*DW-1:0] col_psum;
    logic              out_valid;
    logic              out_ready;
    logic [COL*DW-1:0] out_data;
    logic [9:0]        out_pix;

    modport master (
        output col_valid, col_psum, out_ready,
        input  out_valid, out_data, out_pix
    );

    modport slave (
        input  col_valid, col_psum, out_ready,
        output out_valid, out_data, out_pix
    );
endinterface

// File: rtl/psum_deskew.sv
// psum_deskew
// Realigns the staggered column outputs of a systolic array into whole per-pixel vectors.
// Column c of the K active columns is delayed by K-1-c cycles, so all K lanes line up with
// column K-1. An optional ReLU is applied, and each vector is tagged with its pixel index.
// Vectors are queued in a small output FIFO.
// Ports:
//   clk, nrst         clock; asynchronous active-low reset
//   start             one-cycle pulse: latch config, clear everything, begin a drain
//   num_filter        active column count K
//   num_pixels        vectors to collect per drain
//   relu_en           clamp negative lanes to zero
//   bus (slave)       column inputs plus the out_valid/out_ready output stream
//   busy              high while draining or flushing
//   done              one-cycle pulse when a drain completes
//   overflow          sticky; a vector was dropped because the FIFO was full
//
// state | meaning
// IDLE  | waiting for start; column inputs ignored
// DRAIN | aligning columns and pushing vectors until num_pixels are counted
// FLUSH | collection finished, waiting for the FIFO to empty
// DONE  | single cycle before IDLE; the done pulse follows it
module psum_deskew #(
    parameter int COL        = 32,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [4:0]       num_filter,
    input  logic [9:0]       num_pixels,
    input  logic             relu_en,
    psum_deskew_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (COL > 2) ? $clog2(COL - 1) : 1;
    localparam int VW = COL * DW;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    state_t        state;
    logic [4:0]    k_lat;
    logic [9:0]    np_lat;
    logic          relu_lat;
    logic [9:0]    pix_cnt;

    // dl[c][i] holds column c's input from i+1 cycles ago
    logic [DW-1:0] dl [COL][COL-1];
    logic [DW-1:0] col_in [COL];

    logic [VW-1:0] fifo_data [FIFO_DEPTH];
    logic [9:0]    fifo_pix [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;

    logic [4:0]    k_in;
    logic [VW-1:0] vec;
    logic          algn;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;

    assign k_in = (int'(num_filter) > COL) ? 5'(COL) : num_filter;

    // Inputs are masked outside DRAIN and when a column is not valid, so idle-time
    // traffic never reaches the delay lines.
    always_comb begin
        for (int c = 0; c < COL; c++) begin
            col_in[c] = (state == DRAIN && bus.col_valid[c]) ? bus.col_psum[c*DW +: DW] : '0;
        end
    end

    always_comb begin
        logic [DW-1:0] lane;
        lane = '0;
        vec  = '0;
        for (int c = 0; c < COL; c++) begin
            lane = '0;
            if (c < int'(k_lat)) begin
                if (c == int'(k_lat) - 1) begin
                    lane = col_in[c];
                end else begin
                    lane = dl[c][TW'(int'(k_lat) - 2 - c)];
                end
                if (relu_lat && lane[DW-1]) begin
                    lane = '0;
                end
            end
            vec[c*DW +: DW] = lane;
        end
        algn = 1'b0;
        if (k_lat != 5'd0) begin
            algn = (state == DRAIN) && bus.col_valid[k_lat - 5'd1];
        end
    end

    assign push_req = algn && !start;
    assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
    assign pop      = bus.out_valid && bus.out_ready;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign cnt_nxt  = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    assign bus.out_valid = (cnt != '0);
    assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
    assign bus.out_pix   = bus.out_valid ? fifo_pix[rd_ptr] : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            k_lat    <= '0;
            np_lat   <= '0;
            relu_lat <= 1'b0;
            pix_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            for (int c = 0; c < COL; c++) begin
                for (int i = 0; i < COL - 1; i++) begin
                    dl[c][i] <= '0;
                end
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pix[i]  <= '0;
            end
        end else begin
            done <= 1'b0;
            for (int c = 0; c < COL; c++) begin
                dl[c][0] <= start ? '0 : col_in[c];
                for (int i = 1; i < COL - 1; i++) begin
                    dl[c][i] <= start ? '0 : dl[c][i-1];
                end
            end

            if (start) begin
                k_lat    <= k_in;
                np_lat   <= num_pixels;
                relu_lat <= relu_en;
                pix_cnt  <= '0;
                overflow <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
                if (k_in == 5'd0 || num_pixels == 10'd0) begin
                    state <= DONE;
                    busy  <= 1'b0;
                end else begin
                    state <= DRAIN;
                    busy  <= 1'b1;
                end
            end else begin
                if (push) begin
                    fifo_data[wr_ptr] <= vec;
                    fifo_pix[wr_ptr]  <= pix_cnt;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                cnt <= cnt_nxt;
                if (drop) begin
                    overflow <= 1'b1;
                end

                unique case (state)
                    DRAIN: begin
                        // Dropped vectors still consume a pixel index.
                        if (push_req) begin
                            pix_cnt <= pix_cnt + 10'd1;
                            if (pix_cnt + 10'd1 == np_lat) begin
                                state <= FLUSH;
                            end
                        end
                    end
                    FLUSH: begin
                        if (cnt_nxt == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_psum_deskew.sv
module tb_psum_deskew;
    localparam int COL   = 32;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int VW    = COL * DW;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic       relu_en = 1'b0;
    logic [4:0] num_filter = '0;
    logic [9:0] num_pixels = '0;
    logic       busy;
    logic       done;
    logic       overflow;

    psum_deskew_if #(.COL(COL), .DW(DW)) bus ();

    psum_deskew #(.COL(COL), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .num_filter (num_filter),
        .num_pixels (num_pixels),
        .relu_en    (relu_en),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [VW-1:0] d;
        int            p;
    } ent_t;

    ent_t          mq[$];
    logic [VW-1:0] hist[$];
    logic [VW-1:0] m_in;
    logic [VW-1:0] m_tmp;
    logic [DW-1:0] m_v;
    ent_t          m_e;
    bit            m_coll = 0;
    bit            m_flush = 0;
    bit            m_ovf = 0;
    bit            m_relu = 0;
    int            m_k = 0;
    int            m_np = 0;
    int            m_pix = 0;
    int            ecount = 0;
    int            done_edge = -1;
    bit            chk_en = 0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mq.delete();
            hist.delete();
            m_coll = 0;
            m_flush = 0;
            m_ovf = 0;
            m_pix = 0;
            done_edge = -1;
        end else begin
            ecount++;
            if (start) begin
                mq.delete();
                hist.delete();
                m_ovf = 0;
                m_pix = 0;
                done_edge = -1;
                m_k = int'(num_filter);
                m_np = int'(num_pixels);
                m_relu = relu_en;
                m_flush = 0;
                if (m_k == 0 || m_np == 0) begin
                    m_coll = 0;
                    done_edge = ecount + 1;
                end else begin
                    m_coll = 1;
                end
            end else begin
                if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
                m_in = '0;
                if (m_coll) begin
                    for (int c = 0; c < COL; c++) begin
                        if (bus.col_valid[c]) m_in[c*DW +: DW] = bus.col_psum[c*DW +: DW];
                    end
                end
                hist.push_front(m_in);
                if (hist.size() > COL) void'(hist.pop_back());
                if (m_flush) begin
                    if (mq.size() == 0) begin
                        m_flush = 0;
                        done_edge = ecount + 1;
                    end
                end else if (m_coll && bus.col_valid[m_k-1]) begin
                    // lane c shows what column c presented K-1-c cycles ago
                    m_e.d = '0;
                    for (int c = 0; c < m_k; c++) begin
                        m_v = '0;
                        if (m_k - 1 - c < hist.size()) begin
                            m_tmp = hist[m_k-1-c];
                            m_v = m_tmp[c*DW +: DW];
                        end
                        if (m_relu && $signed(m_v) < 0) m_v = '0;
                        m_e.d[c*DW +: DW] = m_v;
                    end
                    m_e.p = m_pix;
                    if (mq.size() < DEPTH) mq.push_back(m_e);
                    else m_ovf = 1;
                    m_pix++;
                    if (m_pix == m_np) begin
                        m_coll = 0;
                        m_flush = 1;
                    end
                end
            end
        end
    end

    logic [VW-1:0] acc_d[$];
    int            acc_p[$];

    always @(negedge clk) begin
        if (chk_en && nrst) begin
            chk1("out_valid", bus.out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chkv("out_data", bus.out_data, mq[0].d);
                chkn("out_pix", int'(bus.out_pix), mq[0].p);
            end
            chk1("busy", busy, m_coll || m_flush);
            chk1("done", done, ecount == done_edge);
            chk1("overflow", overflow, m_ovf);
            if (done) n_done++;
            if (bus.out_valid && bus.out_ready) begin
                acc_d.push_back(bus.out_data);
                acc_p.push_back(int'(bus.out_pix));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] tv [COL][8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int k, input int np, input bit relu);
        num_filter = 5'(k);
        num_pixels = 10'(np);
        relu_en = relu;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // column c presents pixel p in cycle c+p after start
    task automatic feed(input int k, input int np, input int ncyc, input bit tog);
        for (int t = 0; t < ncyc; t++) begin
            bus.col_valid = '0;
            bus.col_psum = '0;
            for (int c = 0; c < k; c++) begin
                if (t - c >= 0 && t - c < np) begin
                    bus.col_valid[c] = 1'b1;
                    bus.col_psum[c*DW +: DW] = tv[c][t-c];
                end
            end
            if (tog) bus.out_ready = t[0];
            tick();
        end
        bus.col_valid = '0;
        bus.col_psum = '0;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk1(name, got, 1'b1);
        tick();
    endtask

    task automatic clear_acc();
        acc_d.delete();
        acc_p.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int nd0;

    initial begin
        bus.col_valid = '0;
        bus.col_psum = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < COL; c++)
            for (int p = 0; p < 8; p++) tv[c][p] = '0;

        // reset state
        nrst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chkv("rst_out_data", bus.out_data, '0);
        chkn("rst_out_pix", int'(bus.out_pix), 0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        nrst = 1'b1;
        chk_en = 1;
        tick();

        // K=3, two pixels, staggered columns
        tv[0][0] = 16'h0A00; tv[0][1] = 16'h0A01;
        tv[1][0] = 16'h0B00; tv[1][1] = 16'h0B01;
        tv[2][0] = 16'h0C00; tv[2][1] = 16'h0C01;
        bus.out_ready = 1'b1;
        clear_acc();
        nd0 = n_done;
        do_start(3, 2, 0);
        feed(3, 2, 4, 0);
        wait_done("t1_done");
        tick();
        chkn("t1_count", acc_p.size(), 2);
        chkn("t1_done_pulses", n_done - nd0, 1);
        if (acc_p.size() == 2) begin
            chkn("t1_pix0", acc_p[0], 0);
            chkn("t1_pix1", acc_p[1], 1);
            chkv("t1_v0_lo", acc_d[0] & VW'(48'hFFFF_FFFF_FFFF), VW'(48'h0C00_0B00_0A00));
            chkv("t1_v1_lo", acc_d[1] & VW'(48'hFFFF_FFFF_FFFF), VW'(48'h0C01_0B01_0A01));
            chkv("t1_v0_hi", acc_d[0] >> 48, '0);
            chkv("t1_v1_hi", acc_d[1] >> 48, '0);
        end

        // ReLU on and off with a negative lane
        tv[0][0] = 16'h0007;
        tv[1][0] = 16'hFFFB;
        clear_acc();
        do_start(2, 1, 1);
        feed(2, 1, 2, 0);
        wait_done("t2_done");
        chkn("t2_count", acc_p.size(), 1);
        if (acc_p.size() == 1) chkv("t2_relu_vec", acc_d[0], VW'(32'h0000_0007));
        clear_acc();
        do_start(2, 1, 0);
        feed(2, 1, 2, 0);
        wait_done("t2b_done");
        chkn("t2b_count", acc_p.size(), 1);
        if (acc_p.size() == 1) chkv("t2b_raw_vec", acc_d[0], VW'(32'hFFFB_0007));

        // backpressure with overflow
        for (int p = 0; p < 6; p++) tv[0][p] = 16'h3000 + 16'(p);
        bus.out_ready = 1'b0;
        clear_acc();
        do_start(1, 6, 0);
        feed(1, 6, 6, 0);
        @(negedge clk);
        chk1("t3_overflow", overflow, 1'b1);
        chk1("t3_held_valid", bus.out_valid, 1'b1);
        chkn("t3_head_pix", int'(bus.out_pix), 0);
        tick();
        bus.out_ready = 1'b1;
        wait_done("t3_done");
        chkn("t3_count", acc_p.size(), 4);
        if (acc_p.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chkn("t3_pix", acc_p[i], i);
                chkv("t3_data", acc_d[i], VW'(16'h3000 + 16'(i)));
            end
        end

        // K=0: straight to done
        clear_acc();
        do_start(0, 5, 0);
        @(negedge clk);
        chk1("k0_done_early", done, 1'b0);
        tick();
        @(negedge clk);
        chk1("k0_done", done, 1'b1);
        repeat (3) tick();
        chkn("k0_vectors", acc_p.size(), 0);

        // reset in the middle of a drain
        for (int p = 0; p < 8; p++) tv[0][p] = 16'h5000 + 16'(p);
        bus.out_ready = 1'b0;
        do_start(1, 8, 0);
        feed(1, 8, 2, 0);
        @(negedge clk);
        chk1("t5_queued", bus.out_valid, 1'b1);
        nd0 = n_done;
        #2;
        nrst = 1'b0;
        #1;
        chk1("t5_rst_valid", bus.out_valid, 1'b0);
        chk1("t5_rst_busy", busy, 1'b0);
        chk1("t5_rst_ovf", overflow, 1'b0);
        tick();
        nrst = 1'b1;
        repeat (6) tick();
        chkn("t5_no_done", n_done - nd0, 0);

        // restart mid-drain with K=4
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 4; p++) tv[c][p] = 16'h6000 + 16'(c * 16 + p);
        do_start(2, 4, 0);
        feed(2, 4, 3, 0);
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 2; p++) tv[c][p] = 16'h7000 + 16'(c * 256 + p);
        do_start(4, 2, 0);
        @(negedge clk);
        chk1("t6_fifo_cleared", bus.out_valid, 1'b0);
        clear_acc();
        bus.out_ready = 1'b1;
        feed(4, 2, 5, 0);
        wait_done("t6_done");
        chkn("t6_count", acc_p.size(), 2);
        if (acc_p.size() == 2) begin
            chkn("t6_pix0", acc_p[0], 0);
            chkn("t6_pix1", acc_p[1], 1);
            chkv("t6_v0", acc_d[0], VW'(64'h7300_7200_7100_7000));
            chkv("t6_v1", acc_d[1], VW'(64'h7301_7201_7101_7001));
        end

        // toggling ready during collection
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 4; p++) tv[c][p] = 16'h8000 + 16'(c * 16 + p);
        clear_acc();
        do_start(3, 4, 0);
        feed(3, 4, 6, 1);
        bus.out_ready = 1'b1;
        wait_done("t7_done");
        chkn("t7_count", acc_p.size(), 4);
        if (acc_p.size() == 4) begin
            for (int i = 0; i < 4; i++) chkn("t7_pix", acc_p[i], i);
            chkv("t7_v3", acc_d[3], VW'(48'h8023_8013_8003));
        end

        // column traffic while idle is ignored
        bus.col_valid = '1;
        bus.col_psum = {COL{16'h1234}};
        repeat (4) tick();
        @(negedge clk);
        chk1("idle_ignored", bus.out_valid, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        bus.col_valid = '0;
        bus.col_psum = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
